// File: rtl/rgb_frame_fx_if.sv
// rgb_frame_fx_if: pixel bus carrying RGB, valid, syncs and effect mode.
interface rgb_frame_fx_if;
  logic [9:0] red, green, blue;
  logic dval, hs, vs;
  logic [2:0] mode;
  modport master(output red, green, blue, dval, hs, vs, mode);
  modport slave(input red, green, blue, dval, hs, vs, mode);
endinterface

// File: rtl/rgb_frame_fx.sv
// rgb_frame_fx: frame-stable RGB effects in a 2-stage pipeline, mode adopted on iVS fall.
// Define RGB_FRAME_FX_BLANK_EN to output black whenever the pixel is not valid.
module rgb_frame_fx #(
  parameter int POST_BITS = 3,
  parameter int THRESH = 512,
  parameter int BRIGHT_OFS = 128
) (
  input logic iCLK,
  input logic iRST_N,
  rgb_frame_fx_if.slave src,
  rgb_frame_fx_if.master dst
);
  localparam logic [9:0] POST_MASK = 10'(~((1 << POST_BITS) - 1));
  logic vs_prev;
  logic [2:0] mode_q, s1_mode;
  logic [9:0] s1_r, s1_g, s1_b, s1_gray, r2, g2, b2;
  logic s1_dval, s1_hs, s1_vs;
  logic [11:0] sum;
  assign sum = 12'(src.red) + {1'b0, src.green, 1'b0} + 12'(src.blue);
  assign dst.mode = mode_q;
  function automatic logic [9:0] bright(input logic [9:0] x);
    logic [10:0] s;
    s = {1'b0, x} + 11'(BRIGHT_OFS);
    return s[10] ? 10'h3ff : s[9:0];
  endfunction
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      vs_prev <= 1'b1;
      mode_q <= '0;
      {s1_r, s1_g, s1_b, s1_gray, s1_mode, s1_dval} <= '0;
      {s1_hs, s1_vs} <= 2'b11;
      {dst.red, dst.green, dst.blue, dst.dval} <= '0;
      {dst.hs, dst.vs} <= 2'b11;
    end else begin
      vs_prev <= src.vs;
      if (vs_prev && !src.vs) mode_q <= src.mode;
      {s1_r, s1_g, s1_b} <= {src.red, src.green, src.blue};
      {s1_dval, s1_hs, s1_vs} <= {src.dval, src.hs, src.vs};
      s1_gray <= sum[11:2];
      s1_mode <= mode_q;
      {dst.red, dst.green, dst.blue} <= {r2, g2, b2};
      {dst.dval, dst.hs, dst.vs} <= {s1_dval, s1_hs, s1_vs};
    end
  end
  always_comb begin
    {r2, g2, b2} = {s1_r, s1_g, s1_b};
    case (s1_mode)
      3'd1: {r2, g2, b2} = {3{s1_gray}};
      3'd2: {r2, g2, b2} = ~{s1_r, s1_g, s1_b};
      3'd3: {r2, g2, b2} = {s1_r & POST_MASK, s1_g & POST_MASK, s1_b & POST_MASK};
      3'd4: {r2, g2, b2} = {30{s1_gray >= 10'(THRESH)}};
      3'd5: {r2, g2, b2} = {bright(s1_r), bright(s1_g), bright(s1_b)};
      3'd6: {g2, b2} = '0;
      default: ;
    endcase
`ifdef RGB_FRAME_FX_BLANK_EN
    if (!s1_dval) {r2, g2, b2} = '0;
`endif
  end
endmodule

// File: tb/tb_rgb_frame_fx.sv
// tb_rgb_frame_fx: directed and randomized checks of rgb_frame_fx against a frame-level model.
module tb_rgb_frame_fx;
  localparam int PB = 3, TH = 512, BO = 128;
  localparam logic [32:0] RST = {30'd0, 1'b0, 1'b1, 1'b1};
  logic clk = 0, rst_n = 0;
  bit live = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rgb_frame_fx_if src();
  rgb_frame_fx_if dst();
  rgb_frame_fx dut (.iCLK(clk), .iRST_N(rst_n), .src(src), .dst(dst));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] fx(input int m, input int r, input int g, input int b, input bit dv);
    int x[3];
    int o[3];
    int gray;
    x = '{r, g, b};
    gray = (r + 2 * g + b) / 4;
    for (int i = 0; i < 3; i++)
      case (m)
        1: o[i] = gray;
        2: o[i] = 1023 - x[i];
        3: o[i] = (x[i] >> PB) << PB;
        4: o[i] = gray >= TH ? 1023 : 0;
        5: o[i] = x[i] + BO > 1023 ? 1023 : x[i] + BO;
        6: o[i] = i == 0 ? x[i] : 0;
        default: o[i] = x[i];
      endcase
`ifdef RGB_FRAME_FX_BLANK_EN
    if (!dv) o = '{0, 0, 0};
`endif
    return {10'(o[0]), 10'(o[1]), 10'(o[2])};
  endfunction

  // Model: expected output word for a pixel is fixed when it enters, using the frame's mode then.
  logic [32:0] e1, e2;
  logic [2:0] mm;
  logic pvs;
  always @(posedge clk)
    if (!rst_n) begin
      e1 <= RST;
      e2 <= RST;
      mm <= '0;
      pvs <= 1'b1;
    end else begin
      e2 <= e1;
      e1 <= {fx(int'(mm), int'(src.red), int'(src.green), int'(src.blue), src.dval), src.dval, src.hs, src.vs};
      if (pvs && !src.vs) mm <= src.mode;
      pvs <= src.vs;
    end

  always @(negedge clk)
    if (live) begin
      chk("pipe", 64'({dst.red, dst.green, dst.blue, dst.dval, dst.hs, dst.vs}), 64'(e2));
      chk("mode", 64'(dst.mode), 64'(mm));
    end

  task automatic step(input int r, input int g, input int b, input bit dv, input bit hs, input bit vs, input int m);
    src.red = 10'(r);
    src.green = 10'(g);
    src.blue = 10'(b);
    src.dval = dv;
    src.hs = hs;
    src.vs = vs;
    src.mode = 3'(m);
    @(posedge clk);
    #1;
  endtask

  task automatic out_is(input string tag, input logic [29:0] rgb);
    chk(tag, 64'({dst.red, dst.green, dst.blue}), 64'(rgb));
  endtask

  initial begin
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    live = 1;
    out_is("rst_rgb", 30'd0);
    chk("rst_ctl", 64'({dst.dval, dst.hs, dst.vs, dst.mode}), 64'(6'b011000));
    rst_n = 1;
    step(100, 200, 300, 1, 1, 1, 2);
    step(0, 0, 0, 0, 1, 1, 2);
    out_is("mode0_pass", {10'd100, 10'd200, 10'd300});
    chk("mode_still0", 64'(dst.mode), 64'd0);
    step(5, 5, 5, 1, 1, 0, 1);
    chk("mode_latch1", 64'(dst.mode), 64'd1);
    step(100, 200, 300, 1, 1, 0, 2);
    step(0, 0, 0, 0, 1, 0, 2);
    out_is("gray", {3{10'd200}});
    chk("one_latch", 64'(dst.mode), 64'd1);
    step(0, 0, 0, 0, 1, 1, 5);
    step(0, 0, 0, 0, 1, 0, 5);
    step(1000, 895, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    out_is("bright_sat", {10'd1023, 10'd1023, 10'd128});
    step(0, 0, 0, 0, 1, 1, 4);
    step(0, 0, 0, 0, 1, 0, 4);
    step(512, 512, 512, 1, 0, 0, 0);
    step(511, 511, 511, 1, 1, 1, 0);
    out_is("thresh_eq", {3{10'd1023}});
    chk("sync_align0", 64'({dst.hs, dst.vs}), 64'd0);
    step(0, 0, 0, 0, 1, 1, 0);
    out_is("thresh_below", 30'd0);
    chk("sync_align1", 64'({dst.hs, dst.vs}), 64'd3);
    step(0, 0, 0, 0, 1, 0, 2);
    step(0, 0, 0, 0, 1, 0, 3);
    step(0, 0, 0, 0, 1, 1, 3);
    step(1023, 1023, 1023, 1, 1, 0, 3);
    step(1023, 1023, 1023, 1, 1, 0, 3);
    out_is("edge_old_mode", 30'd0);
    step(0, 0, 0, 0, 1, 0, 3);
    out_is("edge_new_mode", {3{10'h3f8}});
    step(0, 0, 0, 0, 1, 1, 2);
    step(0, 0, 0, 0, 1, 0, 2);
    step(400, 300, 200, 1, 0, 0, 2);
    rst_n = 0;
    step(400, 300, 200, 1, 0, 0, 2);
    out_is("midrst_rgb", 30'd0);
    chk("midrst_ctl", 64'({dst.dval, dst.hs, dst.vs, dst.mode}), 64'(6'b011000));
    rst_n = 1;
`ifdef RGB_FRAME_FX_BLANK_EN
    step(777, 777, 777, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    out_is("blank", 30'd0);
`endif
    for (int n = 0; n < 600; n++) begin
      int pick;
      pick = $urandom_range(0, 3);
      rst_n = $urandom_range(0, 39) != 0;
      step(pick == 0 ? 1023 : int'($urandom_range(0, 1023)),
           pick == 1 ? 512 : int'($urandom_range(0, 1023)),
           pick == 2 ? 0 : int'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0 ? ~src.vs : src.vs, int'($urandom_range(0, 7)));
    end
    rst_n = 1;
    step(0, 0, 0, 0, 1, 1, 0);
    live = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rgb_frame_fx.md
Name: rgb_frame_fx

Overview:
- Pixel post-processing stage placed directly downstream of the colour-channel swap stage and upstream of the VGA output controller.
- Applies one of eight frame-stable effects to the 10-bit RGB stream: grayscale, invert, posterize, threshold or brightness.
- The mode input is latched only at the start of vertical sync, so a mode change never tears a frame.
- The RGB data path is a 2-stage pipeline; the data-valid and sync signals are delayed to stay aligned with it.

Parameters:
- POST_BITS, 3: number of LSBs cleared in posterize mode (legal range 1..9).
- THRESH, 512: gray level at or above which threshold mode outputs white.
- BRIGHT_OFS, 128: offset added in brightness mode, with saturation.

Ports:
- iCLK  in  1  pixel clock.
- iRST_N  in  1  synchronous active-low reset.
- iMODE  in  3  requested effect (from switches); may change at any time.
- iRed  in  10  red input.
- iGreen  in  10  green input.
- iBlue  in  10  blue input.
- iDVAL  in  1  input pixel valid.
- iHS  in  1  horizontal sync, active low.
- iVS  in  1  vertical sync, active low.
- oRed  out  10  processed red.
- oGreen  out  10  processed green.
- oBlue  out  10  processed blue.
- oDVAL  out  1  output valid.
- oHS  out  1  delayed horizontal sync.
- oVS  out  1  delayed vertical sync.
- oMODE  out  3  currently active (latched) mode.

Behaviour:
- Clock and reset: single clock iCLK; reset iRST_N is synchronous and active-low, sampled on the rising edge of iCLK.
- Reset values:
  - oRed, oGreen, oBlue = 0.
  - oDVAL = 0.
  - oHS = 1, oVS = 1.
  - oMODE = 0.
  - All pipeline registers = 0; sync pipeline registers = 1.
  - Previous-iVS register = 1.
- Mode latch:
  - Register the previous iVS. A falling edge (prev=1, iVS=0) loads the active mode from iMODE on that edge.
  - iMODE changes outside that edge are ignored.
  - oMODE reflects the active mode register directly (no pipeline delay).
- Stage 1, every cycle, no stall:
  - Register R, G, B, iDVAL, iHS, iVS and the active mode as it stood before the current edge.
  - Compute gray = (R + 2G + B) >> 2, using a 12-bit intermediate sum; the result is 10 bits and never overflows.
- Stage 2, select from the stage-1 mode:
  - 0: pass-through.
  - 1: grayscale; gray on all three channels.
  - 2: invert; 1023 - x per channel.
  - 3: posterize; x with its POST_BITS LSBs forced to 0.
  - 4: threshold; all channels 1023 if gray >= THRESH, else 0.
  - 5: brightness; min(x + BRIGHT_OFS, 1023) per channel, using an 11-bit add.
  - 6: red-only; G = B = 0.
  - 7: reserved; identical to pass-through.
- Latency:
  - Exactly 2 cycles from input to oRed/oGreen/oBlue/oDVAL/oHS/oVS, with all of them mutually aligned.
  - Data is processed regardless of iDVAL; oDVAL qualifies it.
- Boundary cases:
  - Pixel presented in the same cycle as the iVS falling edge: processed with the old mode. Pixels from the next cycle onward use the new mode.
  - iVS held low for many cycles: only one latch occurs, at the edge.
  - Reset asserted mid-frame: on the next edge all outputs take their reset values; the mode returns to 0 and the pipeline contents are discarded.
  - After reset release the first iVS fall is needed to adopt iMODE; until then mode 0 is used.
  - Saturation boundaries: 1023 + offset → 1023. Threshold exactly at THRESH → white.

Optional Feature:
- Macro: RGB_FRAME_FX_BLANK_EN.
- Defined: stage 2 forces oRed/oGreen/oBlue to 0 whenever the stage-1 valid is 0, so blanking intervals output black regardless of input garbage.
- Undefined: RGB passes through the selected effect regardless of valid.
- Timing and latency are identical in both builds.

Test Plan:
- Reset, then iRST_N=1 with iMODE=2 and no iVS edge; drive R=100, G=200, B=300, iDVAL=1 → after 2 cycles out = 100/200/300 (mode still 0), oMODE=0.
- iMODE=1, pulse iVS 1→0; drive R=100, G=200, B=300 → oMODE=1 on the edge-following cycle; 2 cycles later all channels = (100+400+300)>>2 = 200.
- Mode 5 with BRIGHT_OFS=128; input R=1000, G=895, B=0 → out 1023/1023/128.
- Mode 4 with THRESH=512; gray exactly 512 (R=G=B=512) → 1023 on all channels; gray 511 → 0; verify alignment with oHS/oVS toggles delayed exactly 2 cycles.
- Change iMODE from 2 to 3 mid-frame, then in the iVS-fall cycle drive pixel P0 and drive P1 on the next cycle → P0 inverted, P1 posterized (e.g. 0x3FF → 0x3F8 with POST_BITS=3).
- Mode 2 active; assert iRST_N=0 for one cycle mid-line → next cycle outputs 0, oDVAL=0, oHS=oVS=1, oMODE=0. With RGB_FRAME_FX_BLANK_EN defined, iDVAL=0 with R=G=B=777 gives out 0.
